// File: rtl/cache_pkg.sv
// Shared definitions for the cache slice: access-size codes, default
// geometry, line/tag/set typedefs and a size-to-byte-count helper.
// Optional feature macro: CACHE_ASSERT_EN (checked in cache.sv).
package cache_pkg;

  localparam int DEF_N                = 4;
  localparam int DEF_LINE_SIZE        = 128;
  localparam int DEF_WORD_SIZE        = 32;
  localparam int DEF_ASSOCIATIVITY    = 2;
  localparam int DEF_OFFSET_SIZE      = 4;
  localparam int DEF_SET_SIZE         = $clog2(DEF_N / DEF_ASSOCIATIVITY);
  localparam int DEF_TAG_SIZE         = DEF_WORD_SIZE - DEF_SET_SIZE - DEF_OFFSET_SIZE;
  localparam int DEF_SB_ENTRIES       = 4;
  localparam int DEF_SIZE_WRITE_WIDTH = 2;

  localparam logic [DEF_SIZE_WRITE_WIDTH-1:0] BYTE_SIZE      = 2'd0;
  localparam logic [DEF_SIZE_WRITE_WIDTH-1:0] HALF_SIZE      = 2'd1;
  localparam logic [DEF_SIZE_WRITE_WIDTH-1:0] FULL_WORD_SIZE = 2'd2;

  typedef logic [DEF_LINE_SIZE-1:0]        line_t;
  typedef logic [DEF_TAG_SIZE-1:0]         tag_t;
  typedef logic [DEF_SET_SIZE-1:0]         set_t;
  typedef logic [DEF_SIZE_WRITE_WIDTH-1:0] size_t;

  // Number of bytes touched by an access of the given size code.
  function automatic int size_bytes(input size_t size);
    case (size)
      BYTE_SIZE: size_bytes = 1;
      HALF_SIZE: size_bytes = 2;
      default:   size_bytes = 4;
    endcase
  endfunction

endpackage

// File: rtl/cache_load_align.sv
// Selects a byte, halfword or word from a cache line at a byte offset and
// sign-extends it to the word width (little-endian).
// Ports:
//   line   - full cache line
//   offset - byte offset of the access within the line
//   size   - access size code (BYTE_SIZE / HALF_SIZE / FULL_WORD_SIZE)
//   data   - sign-extended result
module cache_load_align
  import cache_pkg::*;
#(
  parameter int LINE_SIZE        = DEF_LINE_SIZE,
  parameter int WORD_SIZE        = DEF_WORD_SIZE,
  parameter int OFFSET_SIZE      = DEF_OFFSET_SIZE,
  parameter int SIZE_WRITE_WIDTH = DEF_SIZE_WRITE_WIDTH
)(
  input  logic [LINE_SIZE-1:0]        line,
  input  logic [OFFSET_SIZE-1:0]      offset,
  input  logic [SIZE_WRITE_WIDTH-1:0] size,
  output logic [WORD_SIZE-1:0]        data
);

  logic [LINE_SIZE-1:0] shifted;

  // Bring the addressed byte down to bit 0 so every size reads from the bottom.
  assign shifted = line >> {offset, 3'b000};

  always_comb begin
    case (size)
      BYTE_SIZE: data = {{(WORD_SIZE-8){shifted[7]}}, shifted[7:0]};
      HALF_SIZE: data = {{(WORD_SIZE-16){shifted[15]}}, shifted[15:0]};
      default:   data = shifted[WORD_SIZE-1:0];
    endcase
  end

endmodule

// File: rtl/cache.sv
// Set-associative, write-back, write-allocate data cache with per-line pin
// counters that keep lines with outstanding store-buffer entries resident.
// Ports:
//   clk, rst (sync, active-low)
//   valid/addr/load_size/store      - pipeline access; hit/read_data combinational
//   mem_req/mem_req_addr            - line fill request (one outstanding)
//   mem_res/mem_res_addr/_data      - fill response
//   mem_write/_addr/_data           - one-cycle dirty victim write-back
//   sb_value/sb_addr/sb_size/wenable/store_success - store-buffer drain port
// Optional feature: define CACHE_ASSERT_EN for simulation assertions on
// pin-counter overflow/underflow, store-buffer misses and stray responses.
module cache
  import cache_pkg::*;
#(
  parameter int N                = DEF_N,
  parameter int LINE_SIZE        = DEF_LINE_SIZE,
  parameter int WORD_SIZE        = DEF_WORD_SIZE,
  parameter int ASSOCIATIVITY    = DEF_ASSOCIATIVITY,
  parameter int OFFSET_SIZE      = DEF_OFFSET_SIZE,
  parameter int SET_SIZE         = $clog2(N / ASSOCIATIVITY),
  parameter int TAG_SIZE         = WORD_SIZE - SET_SIZE - OFFSET_SIZE,
  parameter int SB_ENTRIES       = DEF_SB_ENTRIES,
  parameter int SIZE_WRITE_WIDTH = DEF_SIZE_WRITE_WIDTH,
  parameter int INIT             = 0
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid,
  input  logic [WORD_SIZE-1:0]        addr,
  input  logic [SIZE_WRITE_WIDTH-1:0] load_size,
  input  logic                        store,
  output logic                        hit,
  output logic [WORD_SIZE-1:0]        read_data,
  output logic                        mem_req,
  output logic [WORD_SIZE-1:0]        mem_req_addr,
  input  logic                        mem_res,
  input  logic [WORD_SIZE-1:0]        mem_res_addr,
  input  logic [LINE_SIZE-1:0]        mem_res_data,
  output logic                        mem_write,
  output logic [WORD_SIZE-1:0]        mem_write_addr,
  output logic [LINE_SIZE-1:0]        mem_write_data,
  input  logic [WORD_SIZE-1:0]        sb_value,
  input  logic [WORD_SIZE-1:0]        sb_addr,
  input  logic [SIZE_WRITE_WIDTH-1:0] sb_size,
  input  logic                        wenable,
  output logic                        store_success
);

  localparam int NSETS = N / ASSOCIATIVITY;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int WAY_W = (ASSOCIATIVITY > 1) ? $clog2(ASSOCIATIVITY) : 1;
  localparam int CNT_W = $clog2(SB_ENTRIES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N-1:0]           valid_q, dirty_q;
  logic [TAG_SIZE-1:0]    tag_q  [N];
  logic [LINE_SIZE-1:0]   data_q [N];
  logic [CNT_W-1:0]       pin_q  [N];
  logic [CNT_W-1:0]       pin_d  [N];
  logic [WAY_W-1:0]       rr_q   [NSETS];
  logic                   pend_q;
  logic [WORD_SIZE-1:0]   pend_addr_q;
  logic [CNT_W-1:0]       pend_cnt_q;
  logic                   mem_write_q;
  logic [WORD_SIZE-1:0]   mem_write_addr_q;
  logic [LINE_SIZE-1:0]   mem_write_data_q;

  logic [SET_SIZE-1:0]    ld_set, sb_set, pend_set;
  logic [TAG_SIZE-1:0]    ld_tag, sb_tag;
  logic                   ld_hit, sb_hit;
  logic [IDX_W-1:0]       ld_idx, sb_idx, vic_idx;
  logic [WAY_W-1:0]       vic_way;
  logic                   vic_found;
  logic [WORD_SIZE-1:0]   aligned;
  logic [LINE_SIZE-1:0]   sb_merged, vic_data;
  logic                   vic_dirty;
  logic                   miss, store_hit, sb_write, res_match, fill, fill_store, pend_store;
  logic [CNT_W-1:0]       fill_pin;
  logic                   pin_inc, pin_dec;
  int                     w;
  logic                   unused_bits;

  assign ld_set   = addr[OFFSET_SIZE +: SET_SIZE];
  assign ld_tag   = addr[WORD_SIZE-1 -: TAG_SIZE];
  assign sb_set   = sb_addr[OFFSET_SIZE +: SET_SIZE];
  assign sb_tag   = sb_addr[WORD_SIZE-1 -: TAG_SIZE];
  assign pend_set = pend_addr_q[OFFSET_SIZE +: SET_SIZE];
  assign unused_bits = ^{mem_res_addr[OFFSET_SIZE-1:0], pend_addr_q[OFFSET_SIZE-1:0]};

  // Tag lookup for the pipeline port and the store-buffer port.
  always_comb begin
    ld_hit = 1'b0;
    ld_idx = '0;
    sb_hit = 1'b0;
    sb_idx = '0;
    for (int k = 0; k < ASSOCIATIVITY; k++) begin
      if (valid_q[int'(ld_set)*ASSOCIATIVITY+k] && tag_q[int'(ld_set)*ASSOCIATIVITY+k] == ld_tag) begin
        ld_hit = 1'b1;
        ld_idx = IDX_W'(int'(ld_set)*ASSOCIATIVITY+k);
      end
      if (valid_q[int'(sb_set)*ASSOCIATIVITY+k] && tag_q[int'(sb_set)*ASSOCIATIVITY+k] == sb_tag) begin
        sb_hit = 1'b1;
        sb_idx = IDX_W'(int'(sb_set)*ASSOCIATIVITY+k);
      end
    end
  end

  cache_load_align #(
    .LINE_SIZE(LINE_SIZE), .WORD_SIZE(WORD_SIZE),
    .OFFSET_SIZE(OFFSET_SIZE), .SIZE_WRITE_WIDTH(SIZE_WRITE_WIDTH)
  ) u_align (
    .line(data_q[ld_idx]), .offset(addr[OFFSET_SIZE-1:0]), .size(load_size), .data(aligned)
  );

  assign hit       = ld_hit;
  assign read_data = ld_hit ? aligned : '0;
  assign miss      = valid && !ld_hit;
  assign store_hit = valid && store && ld_hit;
  assign sb_write  = wenable && sb_hit;

  // While a miss is pending the request stays on the pending line address;
  // otherwise a fresh miss is signalled in the same cycle it is seen.
  assign mem_req      = rst && (pend_q || miss);
  assign mem_req_addr = pend_q ? pend_addr_q : {addr[WORD_SIZE-1:OFFSET_SIZE], {OFFSET_SIZE{1'b0}}};
  assign store_success = rst && sb_write;

  assign mem_write      = mem_write_q;
  assign mem_write_addr = mem_write_addr_q;
  assign mem_write_data = mem_write_data_q;

  // Byte-merge the store-buffer value into the line it hits.
  always_comb begin
    sb_merged = data_q[sb_idx];
    for (int b = 0; b < LINE_SIZE/8; b++) begin
      if (b >= int'(sb_addr[OFFSET_SIZE-1:0]) &&
          b < int'(sb_addr[OFFSET_SIZE-1:0]) + size_bytes(sb_size))
        sb_merged[b*8 +: 8] = sb_value[(b-int'(sb_addr[OFFSET_SIZE-1:0]))*8 +: 8];
    end
  end

  // Round-robin victim search starting at the set pointer; pinned ways are
  // skipped. The scan runs backwards so the way closest to the pointer wins.
  always_comb begin
    vic_found = 1'b0;
    vic_way   = '0;
    w         = 0;
    for (int k = ASSOCIATIVITY-1; k >= 0; k--) begin
      w = (int'(rr_q[pend_set]) + k) % ASSOCIATIVITY;
      if (pin_q[int'(pend_set)*ASSOCIATIVITY+w] == '0) begin
        vic_found = 1'b1;
        vic_way   = WAY_W'(w);
      end
    end
  end

  assign vic_idx    = IDX_W'(int'(pend_set)*ASSOCIATIVITY + int'(vic_way));
  assign res_match  = pend_q && mem_res &&
                      (mem_res_addr[WORD_SIZE-1:OFFSET_SIZE] == pend_addr_q[WORD_SIZE-1:OFFSET_SIZE]);
  assign fill       = res_match && vic_found;
  assign pend_store = valid && store &&
                      (addr[WORD_SIZE-1:OFFSET_SIZE] == pend_addr_q[WORD_SIZE-1:OFFSET_SIZE]);
  assign fill_store = pend_store;
  assign fill_pin   = (fill_store && pend_cnt_q != CNT_MAX) ? pend_cnt_q + CNT_W'(1) : pend_cnt_q;

  // A store-buffer write landing on the victim in the fill cycle must not be lost.
  assign vic_data  = (sb_write && sb_idx == vic_idx) ? sb_merged : data_q[vic_idx];
  assign vic_dirty = dirty_q[vic_idx] || (sb_write && sb_idx == vic_idx);

  // Pin counters: a pipeline store and an SB drain on the same line cancel.
  always_comb begin
    pin_inc = 1'b0;
    pin_dec = 1'b0;
    for (int i = 0; i < N; i++) begin
      pin_d[i] = pin_q[i];
      pin_inc  = store_hit && (ld_idx == IDX_W'(i));
      pin_dec  = sb_write && (sb_idx == IDX_W'(i));
      if (pin_inc && !pin_dec && pin_q[i] != CNT_MAX)
        pin_d[i] = pin_q[i] + CNT_W'(1);
      else if (pin_dec && !pin_inc && pin_q[i] != '0)
        pin_d[i] = pin_q[i] - CNT_W'(1);
    end
    if (fill) pin_d[vic_idx] = fill_pin;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q     <= '0;
      dirty_q     <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_cnt_q  <= '0;
      mem_write_q <= 1'b0;
      mem_write_addr_q <= '0;
      mem_write_data_q <= '0;
      for (int i = 0; i < N; i++) pin_q[i] <= '0;
      for (int s = 0; s < NSETS; s++) rr_q[s] <= '0;
      if (INIT != 0) begin
        for (int i = 0; i < N; i++) begin
          data_q[i] <= '0;
          tag_q[i]  <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) pin_q[i] <= pin_d[i];
      mem_write_q <= 1'b0;

      if (sb_write) begin
        data_q[sb_idx]  <= sb_merged;
        dirty_q[sb_idx] <= 1'b1;
      end

      if (!pend_q) begin
        if (miss) begin
          pend_q      <= 1'b1;
          pend_addr_q <= {addr[WORD_SIZE-1:OFFSET_SIZE], {OFFSET_SIZE{1'b0}}};
          pend_cnt_q  <= store ? CNT_W'(1) : '0;
        end
      end else if (fill) begin
        pend_q     <= 1'b0;
        pend_cnt_q <= '0;
        if (valid_q[vic_idx] && vic_dirty) begin
          mem_write_q      <= 1'b1;
          mem_write_addr_q <= {tag_q[vic_idx], pend_set, {OFFSET_SIZE{1'b0}}};
          mem_write_data_q <= vic_data;
        end
        valid_q[vic_idx] <= 1'b1;
        dirty_q[vic_idx] <= 1'b0;
        tag_q[vic_idx]   <= pend_addr_q[WORD_SIZE-1 -: TAG_SIZE];
        data_q[vic_idx]  <= mem_res_data;
        rr_q[pend_set]   <= WAY_W'((int'(vic_way) + 1) % ASSOCIATIVITY);
      end else if (pend_store && pend_cnt_q != CNT_MAX) begin
        pend_cnt_q <= pend_cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef CACHE_ASSERT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      if (store_hit && !(sb_write && sb_idx == ld_idx))
        assert (pin_q[ld_idx] != CNT_MAX) else $error("cache: pin counter overflow");
      if (fill && fill_store)
        assert (pend_cnt_q != CNT_MAX) else $error("cache: pending pin counter overflow");
      if (sb_write && !(store_hit && sb_idx == ld_idx))
        assert (pin_q[sb_idx] != '0) else $error("cache: pin counter underflow");
      if (wenable)
        assert (sb_hit) else $error("cache: store-buffer write missed");
      if (mem_res)
        assert (pend_q) else $error("cache: mem_res without pending mem_req");
    end
  end
`endif

endmodule

// File: tb/tb_cache.sv
// Self-checking bench for the cache: reset, miss/fill with pinning, loads,
// store pinning, store-buffer drains, pinned-set deferral, dirty eviction,
// counter saturation and reset during a miss.
module tb_cache;
  import cache_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         valid, store, mem_res, wenable;
  logic [31:0]  addr, mem_res_addr, sb_value, sb_addr;
  logic [1:0]   load_size, sb_size;
  logic [127:0] mem_res_data;
  logic         hit, mem_req, mem_write, store_success;
  logic [31:0]  read_data, mem_req_addr, mem_write_addr;
  logic [127:0] mem_write_data;

  localparam logic [127:0] FILL1 = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF7F;
  localparam logic [127:0] FILL2 = 128'hCAFEBABE_00000000_11111111_80008001;
  localparam logic [127:0] FILL3 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] VIC   = 128'hFFFFFFFF_BEEFFFFF_FFFFA5FF_12345678;

  typedef struct {
    logic [31:0] data;
    logic        hit;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  cache dut (
    .clk(clk), .rst(rst), .valid(valid), .addr(addr), .load_size(load_size), .store(store),
    .hit(hit), .read_data(read_data), .mem_req(mem_req), .mem_req_addr(mem_req_addr),
    .mem_res(mem_res), .mem_res_addr(mem_res_addr), .mem_res_data(mem_res_data),
    .mem_write(mem_write), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .sb_value(sb_value), .sb_addr(sb_addr), .sb_size(sb_size), .wenable(wenable),
    .store_success(store_success)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clear_inputs();
    valid = 0; store = 0; addr = 0; load_size = FULL_WORD_SIZE;
    mem_res = 0; mem_res_addr = 0; mem_res_data = 0;
    wenable = 0; sb_value = 0; sb_addr = 0; sb_size = FULL_WORD_SIZE;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives a lookup and records what the bench expects it to return.
  task automatic drive_load(input logic [31:0] a, input logic [1:0] sz,
                            input logic [31:0] d, input logic h);
    exp_t e;
    addr = a; load_size = sz; valid = h; store = 0;
    e.data = d; e.hit = h;
    exp_q.push_back(e);
  endtask

  task automatic sb_drive(input logic [31:0] a, input logic [31:0] v, input logic [1:0] sz);
    wenable = 1; sb_addr = a; sb_value = v; sb_size = sz;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0; valid = 1; store = 1; addr = 128; wenable = 1; sb_addr = 128;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
    checks++; if (store_success !== 1'b0) begin failures++; $display("[TB] FAIL reset_store_success: got %b expected 0", store_success); end
    next_cycle();
    next_cycle();
    rst = 1; clear_inputs(); addr = 128;
    @(negedge clk);
    checks++; if (hit !== 1'b0) begin failures++; $display("[TB] FAIL reset_hit: got %b expected 0", hit); end
    checks++; if (read_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_read_data: got %h expected 0", read_data); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_write: got %b expected 0", mem_write); end
    clear_inputs();
  endtask

  task automatic test_miss_fill();
    next_cycle();
    valid = 1; store = 1; addr = 128;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin failures++; $display("[TB] FAIL miss_mem_req: got %b expected 1", mem_req); end
    checks++; if (mem_req_addr !== 32'd128) begin failures++; $display("[TB] FAIL miss_req_addr: got %0d expected 128", mem_req_addr); end
    checks++; if (hit !== 1'b0) begin failures++; $display("[TB] FAIL miss_hit: got %b expected 0", hit); end
    next_cycle();
    checks++; if (dut.pend_cnt_q !== 3'd1) begin failures++; $display("[TB] FAIL pending_count: got %0d expected 1", dut.pend_cnt_q); end
    mem_res = 1; mem_res_addr = 128; mem_res_data = FILL1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin failures++; $display("[TB] FAIL miss_held: got %b expected 1", mem_req); end
    next_cycle();
    clear_inputs(); addr = 128;
    checks++; if (dut.pin_q[0] !== 3'd2) begin failures++; $display("[TB] FAIL fill_pin: got %0d expected 2", dut.pin_q[0]); end
    @(negedge clk);
    checks++; if (hit !== 1'b1) begin failures++; $display("[TB] FAIL fill_hit: got %b expected 1", hit); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL fill_req_drop: got %b expected 0", mem_req); end
    clear_inputs();
  endtask

  task automatic test_load();
    logic [31:0] la [6];
    logic [1:0]  ls [6];
    logic [31:0] ld [6];
    logic        lh [6];
    exp_t e;
    la = '{32'd128, 32'd128, 32'd132, 32'd128, 32'd129, 32'd256};
    ls = '{FULL_WORD_SIZE, BYTE_SIZE, FULL_WORD_SIZE, HALF_SIZE, BYTE_SIZE, FULL_WORD_SIZE};
    ld = '{32'hFFFFFF7F, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF7F, 32'hFFFFFFFF, 32'h0};
    lh = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      drive_load(la[i], ls[i], ld[i], lh[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (read_data !== e.data) begin failures++; $display("[TB] FAIL load_data[%0d]: got %h expected %h", i, read_data, e.data); end
      checks++; if (hit !== e.hit) begin failures++; $display("[TB] FAIL load_hit[%0d]: got %b expected %b", i, hit, e.hit); end
      clear_inputs();
    end
  endtask

  task automatic test_store_pin();
    next_cycle();
    valid = 1; store = 1; addr = 130;
    @(negedge clk);
    checks++; if (hit !== 1'b1) begin failures++; $display("[TB] FAIL store_hit: got %b expected 1", hit); end
    next_cycle();
    clear_inputs();
    checks++; if (dut.pin_q[0] !== 3'd3) begin failures++; $display("[TB] FAIL store_pin: got %0d expected 3", dut.pin_q[0]); end
    // Pipeline store and SB drain to the same line cancel out.
    valid = 1; store = 1; addr = 128; sb_drive(128, 32'h12345678, FULL_WORD_SIZE);
    @(negedge clk);
    checks++; if (store_success !== 1'b1) begin failures++; $display("[TB] FAIL same_cycle_success: got %b expected 1", store_success); end
    next_cycle();
    clear_inputs();
    checks++; if (dut.pin_q[0] !== 3'd3) begin failures++; $display("[TB] FAIL same_cycle_pin: got %0d expected 3", dut.pin_q[0]); end
  endtask

  task automatic test_sb_write();
    exp_t e;
    logic [31:0] la [5];
    logic [1:0]  ls [5];
    logic [31:0] ld [5];
    for (int i = 0; i < 4; i++) begin
      sb_drive(128, 32'h12345678, FULL_WORD_SIZE);
      @(negedge clk);
      checks++; if (store_success !== 1'b1) begin failures++; $display("[TB] FAIL sb_success[%0d]: got %b expected 1", i, store_success); end
      next_cycle();
      clear_inputs();
      checks++; if (dut.pin_q[0] !== ((i < 3) ? 3'(2 - i) : 3'd0)) begin failures++; $display("[TB] FAIL sb_pin[%0d]: got %0d expected %0d", i, dut.pin_q[0], (i < 3) ? (2 - i) : 0); end
    end
    sb_drive(256, 32'hDEADBEEF, FULL_WORD_SIZE);
    @(negedge clk);
    checks++; if (store_success !== 1'b0) begin failures++; $display("[TB] FAIL sb_miss_success: got %b expected 0", store_success); end
    next_cycle();
    clear_inputs();
    sb_drive(133, 32'h000000A5, BYTE_SIZE);
    next_cycle();
    clear_inputs();
    sb_drive(138, 32'h0000BEEF, HALF_SIZE);
    next_cycle();
    clear_inputs();
    la = '{32'd130, 32'd128, 32'd130, 32'd133, 32'd138};
    ls = '{BYTE_SIZE, FULL_WORD_SIZE, HALF_SIZE, BYTE_SIZE, HALF_SIZE};
    ld = '{32'h00000034, 32'h12345678, 32'h00001234, 32'hFFFFFFA5, 32'hFFFFBEEF};
    for (int i = 0; i < 5; i++) begin
      drive_load(la[i], ls[i], ld[i], 1'b1);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (read_data !== e.data) begin failures++; $display("[TB] FAIL sb_load[%0d]: got %h expected %h", i, read_data, e.data); end
      next_cycle();
      clear_inputs();
    end
  endtask

  task automatic test_evict();
    exp_t e;
    valid = 1; store = 1; addr = 256;
    next_cycle();
    clear_inputs();
    mem_res = 1; mem_res_addr = 256; mem_res_data = FILL2;
    next_cycle();
    clear_inputs();
    checks++; if (dut.pin_q[1] !== 3'd1) begin failures++; $display("[TB] FAIL second_fill_pin: got %0d expected 1", dut.pin_q[1]); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("[TB] FAIL clean_fill_write: got %b expected 0", mem_write); end
    valid = 1; store = 1; addr = 128;
    next_cycle();
    clear_inputs();
    valid = 1; addr = 384;
    @(negedge clk);
    checks++; if (mem_req_addr !== 32'd384) begin failures++; $display("[TB] FAIL third_req_addr: got %0d expected 384", mem_req_addr); end
    next_cycle();
    clear_inputs();
    mem_res = 1; mem_res_addr = 384; mem_res_data = FILL3;
    next_cycle();
    clear_inputs(); addr = 384; #1;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("[TB] FAIL pinned_req_held: got %b expected 1", mem_req); end
    checks++; if (mem_req_addr !== 32'd384) begin failures++; $display("[TB] FAIL pinned_req_addr: got %0d expected 384", mem_req_addr); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("[TB] FAIL pinned_no_write: got %b expected 0", mem_write); end
    checks++; if (hit !== 1'b0) begin failures++; $display("[TB] FAIL pinned_no_fill: got %b expected 0", hit); end
    addr = 128; #1;
    checks++; if (hit !== 1'b1) begin failures++; $display("[TB] FAIL pinned_keep_128: got %b expected 1", hit); end
    addr = 256; #1;
    checks++; if (hit !== 1'b1) begin failures++; $display("[TB] FAIL pinned_keep_256: got %b expected 1", hit); end
    clear_inputs();
    sb_drive(128, 32'h12345678, FULL_WORD_SIZE);
    next_cycle();
    clear_inputs();
    mem_res = 1; mem_res_addr = 384; mem_res_data = FILL3;
    next_cycle();
    clear_inputs();
    checks++; if (mem_write !== 1'b1) begin failures++; $display("[TB] FAIL evict_write: got %b expected 1", mem_write); end
    checks++; if (mem_write_addr !== 32'd128) begin failures++; $display("[TB] FAIL evict_addr: got %0d expected 128", mem_write_addr); end
    checks++; if (mem_write_data !== VIC) begin failures++; $display("[TB] FAIL evict_data: got %h expected %h", mem_write_data, VIC); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL evict_req_drop: got %b expected 0", mem_req); end
    drive_load(384, FULL_WORD_SIZE, 32'h76543210, 1'b1);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (read_data !== e.data) begin failures++; $display("[TB] FAIL evict_load_word: got %h expected %h", read_data, e.data); end
    next_cycle();
    clear_inputs();
    checks++; if (mem_write !== 1'b0) begin failures++; $display("[TB] FAIL evict_write_pulse: got %b expected 0", mem_write); end
    drive_load(392, BYTE_SIZE, 32'hFFFFFFEF, 1'b1);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (read_data !== e.data) begin failures++; $display("[TB] FAIL evict_load_byte: got %h expected %h", read_data, e.data); end
    clear_inputs();
    drive_load(396, HALF_SIZE, 32'h00004567, 1'b1);
    #1; e = exp_q.pop_front();
    checks++; if (read_data !== e.data) begin failures++; $display("[TB] FAIL evict_load_half: got %h expected %h", read_data, e.data); end
    clear_inputs();
    drive_load(128, FULL_WORD_SIZE, 32'h0, 1'b0);
    #1; e = exp_q.pop_front();
    checks++; if (hit !== e.hit) begin failures++; $display("[TB] FAIL evicted_gone: got %b expected %b", hit, e.hit); end
    clear_inputs();
    drive_load(256, FULL_WORD_SIZE, 32'h80008001, 1'b1);
    #1; e = exp_q.pop_front();
    checks++; if (read_data !== e.data) begin failures++; $display("[TB] FAIL other_way_kept: got %h expected %h", read_data, e.data); end
    clear_inputs();
  endtask

  task automatic test_saturate();
    next_cycle();
    valid = 1; store = 1; addr = 384;
    for (int i = 0; i < 8; i++) next_cycle();
    clear_inputs();
    checks++; if (dut.pin_q[0] !== 3'd7) begin failures++; $display("[TB] FAIL pin_saturate: got %0d expected 7", dut.pin_q[0]); end
  endtask

  task automatic test_reset_mid_miss();
    next_cycle();
    valid = 1; addr = 512;
    @(negedge clk);
    checks++; if (mem_req_addr !== 32'd512) begin failures++; $display("[TB] FAIL mid_req_addr: got %0d expected 512", mem_req_addr); end
    next_cycle();
    clear_inputs();
    rst = 0;
    next_cycle();
    rst = 1; mem_res = 1; mem_res_addr = 512; mem_res_data = FILL3;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL mid_req_abandoned: got %b expected 0", mem_req); end
    next_cycle();
    clear_inputs(); addr = 512; #1;
    checks++; if (hit !== 1'b0) begin failures++; $display("[TB] FAIL mid_res_ignored: got %b expected 0", hit); end
    checks++; if (read_data !== 32'h0) begin failures++; $display("[TB] FAIL mid_read_zero: got %h expected 0", read_data); end
    addr = 384; #1;
    checks++; if (hit !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_clears: got %b expected 0", hit); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("[TB] FAIL mid_no_write: got %b expected 0", mem_write); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_load();
    test_store_pin();
    test_sb_write();
    test_evict();
    test_saturate();
    test_reset_mid_miss();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
